rc5_scan_driver: RTL and testbench
==================================

Name: rc5_scan_driver

Overview:
- Initiator for the RC5 accelerator's serial validation port.
- Takes a parallel test vector (key, data, round count, control strobes) and drives it MSB-first onto scan_in under scan_en.
- Holds begin_validate through a programmable apply window, then shifts the 33-bit result out of scan_out and presents it in parallel with a one-cycle valid pulse.
- Sits on the tester/SoC side, wired point-to-point to the accelerator's scan_en/scan_in/begin_validate/scan_out pins.

Parameters:
- IN_LEN, 168, scan-in chain length in bits.
- OUT_LEN, 33, scan-out chain length in bits.
- WAIT_W, 16, width of wait_cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; accepted only in IDLE
- abort  in  1  cancel the sequence in progress
- wait_cycles  in  WAIT_W  apply-window length in cycles; 0 is treated as 1
- vec_key  in  128  key field, chain bits [127:0]
- vec_d_in  in  32  data field, chain bits [159:128]
- vec_num_rounds  in  5  round count, chain bits [164:160]
- vec_load_key  in  1  chain bit [165]
- vec_start_encrypt  in  1  chain bit [166]
- vec_start_decrypt  in  1  chain bit [167]
- busy  out  1  high in any non-IDLE state
- scan_en  out  1  to accelerator, registered
- scan_in  out  1  to accelerator, registered
- begin_validate  out  1  to accelerator, registered
- scan_out  in  1  from accelerator
- res_d_out  out  32  captured d_out
- res_done  out  1  captured done
- res_valid  out  1  one-cycle pulse; result fields are valid

Behaviour:
- Reset (async): state IDLE; busy, scan_en, scan_in, begin_validate, res_valid = 0; res_d_out = 0; res_done = 0.
- Start capture: on start in IDLE at edge T, latch {start_decrypt, start_encrypt, load_key, num_rounds, d_in, key} into a 168-bit shift register. Latch W = max(wait_cycles, 1).
- SHIFT_IN, cycles T+1..T+168:
  - scan_en = 1, begin_validate = 1.
  - scan_in = shift register MSB, so bit 167 goes first and bit 0 goes last.
  - Shift register shifts left each cycle.
  - 8-bit counter runs to IN_LEN-1.
- APPLY, cycles T+169..T+168+W:
  - scan_en = 0, begin_validate = 1, scan_in = 0.
  - Down-counter runs W cycles.
- SHIFT_OUT, cycles T+169+W..T+201+W:
  - scan_en = 1, begin_validate = 1.
  - Each edge, capture reg <= {capture[31:0], scan_out}.
  - First sample is done; then d_out[31] down to d_out[0].
- DONE, cycle T+202+W:
  - scan_en = 0, begin_validate = 0.
  - res_done = capture[32], res_d_out = capture[31:0].
  - res_valid = 1 for exactly this cycle, then IDLE; busy drops.
- Result fields hold until the next res_valid.
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored.
- abort (any non-IDLE state, priority over all transitions):
  - Next cycle scan_en = 0, begin_validate = 0, state IDLE.
  - No res_valid; results unchanged.
  - abort in IDLE has no effect.
- Reset mid-sequence: outputs drop to 0 immediately; the accelerator is left with a partial chain, which is acceptable.
- Counter wrap: never wraps; phase exits are compare-equal to the length.

Optional Feature:
- Macro: RC5_SCAN_EXPECT_EN.
- When defined, adds ports:
  - exp_d_out in 32, exp_done in 1: latched at start.
  - res_match out 1: valid with res_valid; 1 iff captured {done, d_out} equals latched expected; reset 0.
  - err_count out 16: saturating count of mismatches; reset 0; not cleared by abort.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Basic run: key=0, d_in=32'hA5A5_0F0F, num_rounds=12, load_key=1, wait_cycles=4, start.
  - First 8 scan_in bits = 0,0,1,0,1,1,0,0.
  - scan_en high exactly 168 cycles, low 4, high 33.
  - begin_validate high 205 cycles.
- Capture: bench model drives scan_out = done=1 then 32'hDEADBEEF MSB-first.
  - res_valid pulses once at T+206; res_done=1, res_d_out=32'hDEADBEEF.
- wait_cycles=0: apply window is exactly 1 cycle; res_valid at T+203.
- start held high through a whole run: second run begins only after the cycle following res_valid; no start accepted while busy=1.
- abort asserted at SHIFT_IN cycle 50: next cycle scan_en=0, begin_validate=0, busy=0; no res_valid; prior results retained.
- With RC5_SCAN_EXPECT_EN: exp_d_out=32'hDEADBEEF, exp_done=1.
  - Matching response gives res_match=1.
  - A response with bit 0 flipped gives res_match=0 and err_count=1.

Source files
------------

// File: rtl/rc5_scan_driver.sv
// rc5_scan_driver
//   Tester-side initiator for the RC5 accelerator's serial validation port.
//   A parallel test vector is shifted MSB-first onto scan_in under scan_en,
//   begin_validate is held through a programmable apply window, then the
//   33-bit response {done, d_out} is shifted in from scan_out and presented
//   in parallel with a one-cycle res_valid pulse.
//
//   Optional build macro RC5_SCAN_EXPECT_EN adds expected-response checking
//   (exp_d_out/exp_done inputs, res_match/err_count outputs).
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start, abort       request (IDLE only) / cancel a sequence in progress
//   wait_cycles        apply-window length, 0 behaves as 1
//   vec_*              test vector fields (chain bits 167..0)
//   busy               high in any non-IDLE state
//   scan_en, scan_in, begin_validate   registered drives to the accelerator
//   scan_out           serial response from the accelerator
//   res_d_out, res_done, res_valid     captured response and its strobe
//   state_dbg          current FSM state, for observation only
//
// Handshake: start is a level request sampled at a clock edge only while
// IDLE (busy=0); there is no ready signal and no queuing, a request seen
// while busy (including the DONE cycle) is dropped. res_valid is a one-cycle
// pulse with no back-pressure; result fields hold until the next pulse.
module rc5_scan_driver #(
  parameter int IN_LEN  = 168,
  parameter int OUT_LEN = 33,
  parameter int WAIT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WAIT_W-1:0] wait_cycles,
  input  logic [127:0]      vec_key,
  input  logic [31:0]       vec_d_in,
  input  logic [4:0]        vec_num_rounds,
  input  logic              vec_load_key,
  input  logic              vec_start_encrypt,
  input  logic              vec_start_decrypt,
  output logic              busy,
  output logic              scan_en,
  output logic              scan_in,
  output logic              begin_validate,
  input  logic              scan_out,
  output logic [31:0]       res_d_out,
  output logic              res_done,
  output logic              res_valid,
`ifdef RC5_SCAN_EXPECT_EN
  input  logic [31:0]       exp_d_out,
  input  logic              exp_done,
  output logic              res_match,
  output logic [15:0]       err_count,
`endif
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_APPLY     = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             state;
  logic [IN_LEN-1:0]  sreg;
  logic [OUT_LEN-1:0] capture;
  logic [OUT_LEN-1:0] cap_next;
  logic [7:0]         cnt;
  logic [WAIT_W-1:0]  wcnt;
  logic [IN_LEN-1:0]  vec_cat;
`ifdef RC5_SCAN_EXPECT_EN
  logic [OUT_LEN-1:0] exp_lat;
`endif

  assign vec_cat   = {vec_start_decrypt, vec_start_encrypt, vec_load_key,
                      vec_num_rounds, vec_d_in, vec_key};
  // Response as it will look once the current scan_out bit is taken in;
  // used so the DONE-cycle results include the final (d_out[0]) sample.
  assign cap_next  = {capture[OUT_LEN-2:0], scan_out};
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      scan_en        <= 1'b0;
      scan_in        <= 1'b0;
      begin_validate <= 1'b0;
      res_valid      <= 1'b0;
      res_d_out      <= '0;
      res_done       <= 1'b0;
      sreg           <= '0;
      capture        <= '0;
      cnt            <= '0;
      wcnt           <= '0;
`ifdef RC5_SCAN_EXPECT_EN
      exp_lat        <= '0;
      res_match      <= 1'b0;
      err_count      <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Abort wins over every phase exit; results are left untouched.
        state          <= S_IDLE;
        busy           <= 1'b0;
        scan_en        <= 1'b0;
        scan_in        <= 1'b0;
        begin_validate <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              // MSB goes out in the first SHIFT_IN cycle, so it is loaded
              // straight into scan_in and the register keeps the rest.
              sreg           <= vec_cat << 1;
              scan_in        <= vec_cat[IN_LEN-1];
              scan_en        <= 1'b1;
              begin_validate <= 1'b1;
              busy           <= 1'b1;
              cnt            <= '0;
              wcnt           <= (wait_cycles == '0) ? WAIT_W'(1) : wait_cycles;
`ifdef RC5_SCAN_EXPECT_EN
              exp_lat        <= {exp_done, exp_d_out};
`endif
              state          <= S_SHIFT_IN;
            end
          end
          S_SHIFT_IN: begin
            sreg <= sreg << 1;
            cnt  <= cnt + 8'd1;
            if (cnt == 8'(IN_LEN - 1)) begin
              scan_en <= 1'b0;
              scan_in <= 1'b0;
              state   <= S_APPLY;
            end else begin
              scan_in <= sreg[IN_LEN-1];
            end
          end
          S_APPLY: begin
            // wcnt holds the remaining apply cycles including this one.
            if (wcnt == WAIT_W'(1)) begin
              scan_en <= 1'b1;
              cnt     <= '0;
              state   <= S_SHIFT_OUT;
            end else begin
              wcnt <= wcnt - WAIT_W'(1);
            end
          end
          S_SHIFT_OUT: begin
            capture <= cap_next;
            cnt     <= cnt + 8'd1;
            if (cnt == 8'(OUT_LEN - 1)) begin
              scan_en        <= 1'b0;
              begin_validate <= 1'b0;
              res_done       <= cap_next[OUT_LEN-1];
              res_d_out      <= cap_next[31:0];
              res_valid      <= 1'b1;
`ifdef RC5_SCAN_EXPECT_EN
              res_match      <= (cap_next == exp_lat);
              if (cap_next != exp_lat && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
`endif
              state          <= S_DONE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy           <= 1'b0;
            scan_en        <= 1'b0;
            scan_in        <= 1'b0;
            begin_validate <= 1'b0;
            state          <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc5_scan_driver.sv
// tb_rc5_scan_driver
//   Directed-plus-random bench for rc5_scan_driver. Expected pin activity is
//   computed per cycle from the sequence timeline (cycle k after the start
//   edge) and the randomly generated vector/response; the bench also plays
//   the accelerator by driving scan_out.
module tb_rc5_scan_driver;

  localparam int WAIT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              start, abort, scan_out;
  logic [WAIT_W-1:0] wait_cycles;
  logic [127:0]      vec_key;
  logic [31:0]       vec_d_in;
  logic [4:0]        vec_num_rounds;
  logic              vec_load_key, vec_start_encrypt, vec_start_decrypt;
  logic              busy, scan_en, scan_in, begin_validate;
  logic [31:0]       res_d_out;
  logic              res_done, res_valid;
  logic [2:0]        state_dbg;
  logic [31:0]       exp_d_out;
  logic              exp_done;
`ifdef RC5_SCAN_EXPECT_EN
  logic              res_match;
  logic [15:0]       err_count;
`endif

  rc5_scan_driver #(.IN_LEN(168), .OUT_LEN(33), .WAIT_W(WAIT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .wait_cycles       (wait_cycles),
    .vec_key           (vec_key),
    .vec_d_in          (vec_d_in),
    .vec_num_rounds    (vec_num_rounds),
    .vec_load_key      (vec_load_key),
    .vec_start_encrypt (vec_start_encrypt),
    .vec_start_decrypt (vec_start_decrypt),
    .busy              (busy),
    .scan_en           (scan_en),
    .scan_in           (scan_in),
    .begin_validate    (begin_validate),
    .scan_out          (scan_out),
    .res_d_out         (res_d_out),
    .res_done          (res_done),
    .res_valid         (res_valid),
`ifdef RC5_SCAN_EXPECT_EN
    .exp_d_out         (exp_d_out),
    .exp_done          (exp_done),
    .res_match         (res_match),
    .err_count         (err_count),
`endif
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prev_d;      // last result presented
  logic        prev_done;
  int          err_m;       // reference mismatch count

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [167:0] rand_vec();
    logic [167:0] v;
    for (int i = 0; i < 168; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  // ---------------- driver + per-cycle reference ----------------
  // One sequence: start at edge T, then check cycles T+1 .. T+last.
  // abort_at != 0 raises abort during cycle abort_at. hold keeps start high
  // so a second run is expected to begin right after the DONE cycle.
  task automatic do_run(input logic [167:0] vec, input int w_in,
                        input logic [32:0] resp, input logic [32:0] expv,
                        input int abort_at, input bit hold);
    int   w, last, k2;
    logic active, e_busy, e_se, e_bv, e_si, e_valid;
    w = (w_in == 0) ? 1 : w_in;
    @(negedge clk);
    {vec_start_decrypt, vec_start_encrypt, vec_load_key, vec_num_rounds,
     vec_d_in, vec_key} = vec;
    wait_cycles = WAIT_W'(w_in);
    exp_done    = expv[32];
    exp_d_out   = expv[31:0];
    start       = 1'b1;
    abort       = 1'b0;
    @(posedge clk);
    last = (abort_at != 0) ? abort_at + 4 : 203 + w;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      active  = (abort_at == 0) || (k <= abort_at);
      e_busy  = active && (k <= 202 + w);
      e_se    = active && ((k <= 168) || (k >= 169 + w && k <= 201 + w));
      e_bv    = active && (k <= 201 + w);
      e_si    = (active && k <= 168) ? vec[168 - k] : 1'b0;
      e_valid = active && (k == 202 + w);
      if (hold && active && k >= 204 + w) begin
        k2     = k - (203 + w);
        e_busy = 1'b1;
        e_se   = 1'b1;
        e_bv   = 1'b1;
        e_si   = vec[168 - k2];
      end
      if (e_valid) begin
        prev_d    = resp[31:0];
        prev_done = resp[32];
        if (resp != expv) err_m++;
      end
      chk($sformatf("busy k=%0d", k),           64'(busy),           64'(e_busy));
      chk($sformatf("scan_en k=%0d", k),        64'(scan_en),        64'(e_se));
      chk($sformatf("begin_validate k=%0d", k), 64'(begin_validate), 64'(e_bv));
      chk($sformatf("scan_in k=%0d", k),        64'(scan_in),        64'(e_si));
      chk($sformatf("res_valid k=%0d", k),      64'(res_valid),      64'(e_valid));
      chk($sformatf("res_d_out k=%0d", k),      64'(res_d_out),      64'(prev_d));
      chk($sformatf("res_done k=%0d", k),       64'(res_done),       64'(prev_done));
`ifdef RC5_SCAN_EXPECT_EN
      if (e_valid)
        chk($sformatf("res_match k=%0d", k), 64'(res_match), 64'(resp == expv));
      chk($sformatf("err_count k=%0d", k), 64'(err_count), 64'(err_m));
`endif
      // drive for the next edge
      start    = hold && (abort_at == 0 || k < abort_at);
      abort    = (k == abort_at);
      scan_out = (k >= 169 + w && k <= 201 + w) ? resp[32 - (k - 169 - w)]
                                                : 1'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [167:0] v;
  logic [167:0] r;
  logic [32:0]  resp, expv;
  int           w_rand;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; scan_out = 1'b0;
    wait_cycles = '0; vec_key = '0; vec_d_in = '0; vec_num_rounds = '0;
    vec_load_key = 1'b0; vec_start_encrypt = 1'b0; vec_start_decrypt = 1'b0;
    exp_d_out = '0; exp_done = 1'b0;
    prev_d = '0; prev_done = 1'b0; err_m = 0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy",      64'(busy),           64'd0);
    chk("reset scan_en",   64'(scan_en),        64'd0);
    chk("reset scan_in",   64'(scan_in),        64'd0);
    chk("reset begin_val", 64'(begin_validate), 64'd0);
    chk("reset res_valid", 64'(res_valid),      64'd0);
    chk("reset res_d_out", 64'(res_d_out),      64'd0);
    chk("reset res_done",  64'(res_done),       64'd0);
`ifdef RC5_SCAN_EXPECT_EN
    chk("reset res_match", 64'(res_match),      64'd0);
    chk("reset err_count", 64'(err_count),      64'd0);
`endif
    rst = 1'b0;
    // abort while idle must be harmless
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", 64'(busy), 64'd0);

    // basic run: load_key=1, rounds=12, d_in=A5A50F0F, key=0, wait=4
    v = {3'b001, 5'd12, 32'hA5A5_0F0F, 128'h0};
    do_run(v, 4, {1'b1, 32'hDEAD_BEEF}, {1'b1, 32'hDEAD_BEEF}, 0, 1'b0);

    // response with bit 0 flipped against the same expectation
    do_run(rand_vec(), 3, {1'b1, 32'hDEAD_BEEE}, {1'b1, 32'hDEAD_BEEF}, 0, 1'b0);

    // wait_cycles=0 behaves as a single apply cycle
    r = rand_vec(); resp = r[32:0];
    do_run(rand_vec(), 0, resp, {1'b1, 32'hDEAD_BEEF}, 0, 1'b0);

    // random vectors, windows and responses
    for (int i = 0; i < 4; i++) begin
      r = rand_vec(); resp = r[32:0];
      expv = ($urandom_range(0, 1) == 1) ? resp : (resp ^ 33'(1 << $urandom_range(0, 32)));
      w_rand = $urandom_range(0, 6);
      do_run(rand_vec(), w_rand, resp, expv, 0, 1'b0);
    end

    // start held through a whole run, then abort the re-started run
    r = rand_vec(); resp = r[32:0];
    do_run(rand_vec(), 2, resp, resp, 208, 1'b1);

    // abort during SHIFT_IN cycle 50; previous results must remain
    do_run(rand_vec(), 5, 33'h0_1234_5678, 33'h0_1234_5678, 50, 1'b0);

    // asynchronous reset in the middle of a sequence
    @(negedge clk);
    {vec_start_decrypt, vec_start_encrypt, vec_load_key, vec_num_rounds,
     vec_d_in, vec_key} = {8'hFF, 160'h0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid busy before reset", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset busy",      64'(busy),           64'd0);
    chk("mid reset scan_en",   64'(scan_en),        64'd0);
    chk("mid reset begin_val", 64'(begin_validate), 64'd0);
    chk("mid reset res_d_out", 64'(res_d_out),      64'd0);
    chk("mid reset res_done",  64'(res_done),       64'd0);
`ifdef RC5_SCAN_EXPECT_EN
    chk("mid reset err_count", 64'(err_count),      64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
